// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetcher_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_LOOKUP  = 2'd0,
        ST_MEM     = 2'd1,
        ST_FILL    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    // Payload held in the single-entry output register towards the decoder.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            pred_taken;
    } fetch_out_t;

    // PCs are halfword aligned; bit 0 is never stored.
    function automatic logic [XLEN-1:0] halfword_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_jal_predecode.sv
// Combinational JAL predecode: flags a JAL and computes its pc-relative target.
module ifetch_jal_predecode
    import instruction_fetcher_pkg::*;
(
    input  logic [ILEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    output logic            is_jal,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] imm_j;
    logic [4:0]      unused_rd;

    // rd does not influence the predicted target
    assign unused_rd = inst[11:7];

    assign is_jal = (inst[OPC_W-1:0] == OPC_JAL);
    assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign target = pc + imm_j;

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: PC, cache lookup, miss refill from memory, valid/ready to decoder.
// Optional build macro IFETCH_JAL_PREDICT_EN enables JAL target prediction.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] ic_addr,
    output logic            ic_wr,
    output logic [ILEN-1:0] ic_data,
    input  logic            ic_hit,
    input  logic [ILEN-1:0] ic_result,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [ILEN-1:0] mem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_pred_taken
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [ILEN-1:0] fill_data_q, fill_data_d;
    fetch_out_t      out_q, out_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] next_pc;
    logic            hit_pred;
    logic            entry_free;

`ifdef IFETCH_JAL_PREDICT_EN
    logic            is_jal;
    logic [XLEN-1:0] jal_target;

    ifetch_jal_predecode u_predecode (
        .inst   (ic_result),
        .pc     (pc_q),
        .is_jal (is_jal),
        .target (jal_target)
    );

    assign next_pc  = is_jal ? jal_target : (pc_q + XLEN'(4));
    assign hit_pred = is_jal;
`else
    assign next_pc  = pc_q + XLEN'(4);
    assign hit_pred = 1'b0;
`endif

    // Output entry can take a new instruction if empty or being drained this cycle
    assign entry_free = !inst_valid_q || inst_ready;

    // State and datapath registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOOKUP;
            pc_q         <= halfword_align(RESET_PC);
            req_addr_q   <= '0;
            fill_data_q  <= '0;
            out_q        <= '0;
            inst_valid_q <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            fill_data_q  <= fill_data_d;
            out_q        <= out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state, datapath updates and cache/memory strobes
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        fill_data_d   = fill_data_q;
        out_d         = out_q;
        inst_valid_d  = inst_valid_q && !inst_ready;
        ic_addr       = pc_q;
        ic_wr         = 1'b0;
        ic_data       = fill_data_q;
        mem_req_valid = 1'b0;
        mem_req_addr  = req_addr_q;

        unique case (state_q)
            ST_LOOKUP: begin
                if (ic_hit) begin
                    if (entry_free) begin
                        out_d        = '{pc: pc_q, inst: ic_result, pred_taken: hit_pred};
                        inst_valid_d = 1'b1;
                        pc_d         = halfword_align(next_pc);
                    end
                end else begin
                    req_addr_d = pc_q;
                    state_d    = ST_MEM;
                end
            end
            ST_MEM, ST_DISCARD: begin
                mem_req_valid = 1'b1;
                if (mem_resp_valid) begin
                    fill_data_d = mem_resp_data;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                ic_wr   = 1'b1;
                ic_addr = req_addr_q;
                state_d = ST_LOOKUP;
            end
            default: state_d = ST_LOOKUP;
        endcase

        // Redirect overrides the lookup result; an outstanding read still completes
        if (flush) begin
            pc_d         = halfword_align(flush_pc);
            inst_valid_d = 1'b0;
            out_d        = out_q;
            req_addr_d   = req_addr_q;
            unique case (state_q)
                ST_LOOKUP:          state_d = ST_LOOKUP;
                ST_MEM, ST_DISCARD: state_d = mem_resp_valid ? ST_FILL : ST_DISCARD;
                ST_FILL:            state_d = ST_LOOKUP;
                default:            state_d = ST_LOOKUP;
            endcase
        end
    end

    assign inst_valid      = inst_valid_q;
    assign inst            = out_q.inst;
    assign inst_pc         = out_q.pc;
    assign inst_pred_taken = out_q.pred_taken;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher with behavioural cache and memory models.
module tb_instruction_fetcher;

    localparam int unsigned LAT = 3;
`ifdef IFETCH_JAL_PREDICT_EN
    localparam logic        JALP   = 1'b1;
    localparam logic [31:0] NEXT10 = 32'h0000_0030;
`else
    localparam logic        JALP   = 1'b0;
    localparam logic [31:0] NEXT10 = 32'h0000_0014;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, inst_ready;
    logic [31:0] flush_pc;
    logic [31:0] ic_addr, ic_data, ic_result, mem_req_addr, inst, inst_pc;
    logic        ic_wr, ic_hit, mem_req_valid, inst_valid, inst_pred_taken;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    int acc_count = 0;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];

    logic        cache_v [1024];
    logic [31:0] cache_d [1024];

    instruction_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .ic_addr         (ic_addr),
        .ic_wr           (ic_wr),
        .ic_data         (ic_data),
        .ic_hit          (ic_hit),
        .ic_result       (ic_result),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_pred_taken (inst_pred_taken)
    );

    always #5 clk = ~clk;

    // Backing store contents: a JAL x1,+0x20 at 0x10, otherwise non-JAL words
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0200_00EF;
        return {a[27:0], 4'h3};
    endfunction

    // Warm lines: 0x04..0xFC except 0x40, and 0x204..0x20C
    function automatic logic preload(input int idx);
        int a;
        a = idx * 4;
        return ((a >= 4) && (a <= 32'hFC) && (a != 32'h40)) || ((a >= 32'h204) && (a <= 32'h20C));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Cache model: combinational read, write on the strobe
    assign ic_hit    = (ic_addr[31:12] == 20'h0) && cache_v[ic_addr[11:2]];
    assign ic_result = cache_d[ic_addr[11:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) begin
                cache_v[i] <= preload(i);
                cache_d[i] <= word(32'(i) << 2);
            end
        end else if (ic_wr) begin
            cache_v[ic_addr[11:2]] <= 1'b1;
            cache_d[ic_addr[11:2]] <= ic_data;
        end
    end

    // Memory model: fixed latency, advances only while rdy is high
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = '0;
    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (!rst && rdy && mem_req_valid) begin
            if (!pending) begin
                pending = 1'b1;
                cnt     = 0;
                maddr   = mem_req_addr;
                if (req_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_req: got request %h expected none", mem_req_addr);
                end else begin
                    check("mem_req_addr", mem_req_addr, req_q.pop_front());
                end
            end else begin
                cnt++;
                check("mem_req_hold", mem_req_addr, maddr);
                if (cnt == LAT) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = word(maddr);
                    pending        = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted instruction is matched against the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy && !flush && inst_valid && inst_ready) begin
            acc_count++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL inst_unexpected: got pc %h expected no instruction", inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst", inst, e.inst);
                check("inst_pred_taken", 32'(inst_pred_taken), 32'(e.pred));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, a0;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0; inst_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_ic_wr", 32'(ic_wr), 32'd0);
        check("rst_ic_addr", ic_addr, 32'd0);

        // Cold miss at 0
        req_q.push_back(32'h0);
        exp_q.push_back('{pc: 32'h0, inst: word(32'h0), pred: 1'b0});
        rst = 1'b0;
        for (int i = 0; i < 50 && !mem_req_valid; i++) step();
        check("cold_req_seen", 32'(mem_req_valid), 32'd1);
        c0 = cycle;
        for (int i = 0; i < 50 && !inst_valid; i++) step();
        check("cold_inst_valid", 32'(inst_valid), 32'd1);
        c1 = cycle;
        check("miss_latency", 32'(c1 - c0), 32'(LAT + 3));

        // Warm hits drained back to back
        for (int a = 4; a <= 12; a += 4)
            exp_q.push_back('{pc: 32'(a), inst: word(32'(a)), pred: 1'b0});
        a0 = acc_count;
        inst_ready = 1'b1;
        repeat (4) begin
            check("warm_no_mem_req", 32'(mem_req_valid), 32'd0);
            step();
        end
        inst_ready = 1'b0;
        check("warm_accepts", 32'(acc_count - a0), 32'd4);

        // Backpressure on the JAL at 0x10
        repeat (5) begin
            check("bp_inst_valid", 32'(inst_valid), 32'd1);
            check("bp_inst_pc", inst_pc, 32'h10);
            check("bp_inst", inst, word(32'h10));
            check("bp_pred", 32'(inst_pred_taken), 32'(JALP));
            check("bp_pc_held", ic_addr, NEXT10);
            step();
        end
        exp_q.push_back('{pc: 32'h10, inst: word(32'h10), pred: JALP});
        exp_q.push_back('{pc: NEXT10, inst: word(NEXT10), pred: 1'b0});
        a0 = acc_count;
        inst_ready = 1'b1;
        step();
        step();
        inst_ready = 1'b0;
        check("bp_accepts", 32'(acc_count - a0), 32'd2);

        // Flush to 0x100 (miss), then flush to 0x40 while the read is outstanding
        req_q.push_back(32'h100);
        flush = 1'b1; flush_pc = 32'h100;
        step();
        flush = 1'b0;
        for (int i = 0; i < 50 && !mem_req_valid; i++) step();
        check("f_req_seen", 32'(mem_req_valid), 32'd1);
        check("f_req_addr", mem_req_addr, 32'h100);
        req_q.push_back(32'h40);
        exp_q.push_back('{pc: 32'h40, inst: word(32'h40), pred: 1'b0});
        flush = 1'b1; flush_pc = 32'h41;
        step();
        flush = 1'b0;
        check("discard_req_held", 32'(mem_req_valid), 32'd1);
        check("discard_req_addr", mem_req_addr, 32'h100);
        check("discard_no_inst", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 50 && !inst_valid; i++) step();
        check("f_inst_valid", 32'(inst_valid), 32'd1);
        check("fill_100_valid", 32'(cache_v[64]), 32'd1);
        check("fill_100_data", cache_d[64], word(32'h100));
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        // Freeze in the middle of a miss
        req_q.push_back(32'h200);
        exp_q.push_back('{pc: 32'h200, inst: word(32'h200), pred: 1'b0});
        flush = 1'b1; flush_pc = 32'h200;
        step();
        flush = 1'b0;
        for (int i = 0; i < 50 && !mem_req_valid; i++) step();
        check("frz_req_seen", 32'(mem_req_valid), 32'd1);
        rdy = 1'b0;
        repeat (4) begin
            step();
            check("frz_req_valid", 32'(mem_req_valid), 32'd1);
            check("frz_req_addr", mem_req_addr, 32'h200);
            check("frz_inst_valid", 32'(inst_valid), 32'd0);
            check("frz_ic_wr", 32'(ic_wr), 32'd0);
        end
        rdy = 1'b1;
        for (int i = 0; i < 50 && !inst_valid; i++) step();
        check("frz_resume_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        // Freeze with an occupied entry while the decoder signals ready
        step();
        rdy = 1'b0;
        inst_ready = 1'b1;
        repeat (3) begin
            step();
            check("frz2_inst_pc", inst_pc, 32'h204);
            check("frz2_pc_held", ic_addr, 32'h208);
        end
        exp_q.push_back('{pc: 32'h204, inst: word(32'h204), pred: 1'b0});
        rdy = 1'b1;
        step();
        inst_ready = 1'b0;
        repeat (3) step();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
